cpu_phase_monitor: RTL and testbench
====================================

# cpu_phase_monitor

- Receiver-side companion to the CPU phase-strobe generator: it takes the eight phase strobes `clock_1`..`clock_8` and decodes them into a binary phase index.
- It locks onto the rotating one-hot sequence, counts completed instruction cycles, and flags any sequence violation.
- It sits beside the CPU datapath so that downstream logic and debug can use a single encoded phase instead of eight wires.
- It gives early warning of a corrupted phase ring.

## Interface

Parameters:
- `CYC_W`, 16, width of the completed-cycle counter.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clock_1`..`clock_8` input 1 each: phase strobes from the generator. Form vector `v = {clock_8..clock_1}`.
- `clr_err` input 1: synchronous clear of `err_sticky` and `err_count`.
- `phase` output 3: encoded current phase, 0..7 meaning `clock_1`..`clock_8`.
- `phase_valid` output 1: `phase` is meaningful (the FSM is in LOCKED).
- `cycle_done` output 1: one-cycle pulse when `clock_8` completes in LOCKED.
- `cycle_count` output CYC_W: completed instruction cycles; wraps modulo 2^CYC_W.
- `err` output 1: one-cycle pulse on a sequence violation.
- `err_sticky` output 1: set by `err`; held until `clr_err` or `reset`.
- `err_count` output 8: saturating violation count. Present only under the configuration macro.

## Operation

- States: HUNT, LOCKED, FAULT. Encoded state is internal.
- Reset (synchronous, dominant over all other inputs) forces:
  - state = HUNT;
  - `phase` = 0, `phase_valid` = 0, `cycle_done` = 0, `cycle_count` = 0;
  - `err` = 0, `err_sticky` = 0, `err_count` = 0.
- HUNT:
  - `v` == 8'h00 or any pattern other than 8'h01: stay in HUNT, no error. Covers post-reset quiet and stale strobes.
  - `v` == 8'h01: go to LOCKED, `phase` = 0, `phase_valid` = 1.
- LOCKED:
  - Expected next vector is `1 << ((phase+1) mod 8)`.
  - Exact match: stay in LOCKED and set `phase` = (phase+1) mod 8.
  - Match with new `phase` == 7: also pulse `cycle_done`, and increment `cycle_count` at that same edge.
  - Any mismatch (zero, multi-hot, or wrong one-hot): go to FAULT, pulse `err`, set `err_sticky`, set `phase_valid` = 0. `phase` holds its last value.
- FAULT:
  - Lasts exactly one cycle, then unconditionally HUNT.
  - `v` is ignored during FAULT, so a vector of 8'h01 there does not lock.
- `clr_err` and `err` on the same edge: the set wins, so `err_sticky` = 1. Under the macro, `err_count` clears then increments, ending at 1.
- `cycle_count` is not affected by faults; only `reset` clears it.

## Timing

- All outputs are registered.
- Inputs sampled at edge N are reflected on the outputs after edge N. Latency is 1 cycle.
- `phase_valid` rises on the edge that samples 8'h01 in HUNT.
- `err` pulse and `phase_valid` fall occur on the same edge that samples the violation.
- Earliest relock after a fault:
  - Violation sampled at edge N → FAULT after N.
  - Edge N+1 → HUNT.
  - Edge N+2 can sample 8'h01 and lock.
- A healthy ring gives `cycle_done` every 8 cycles, coincident with `phase` = 7.
- `cycle_count` wraps from 2^CYC_W−1 to 0 with no flag.

## Configuration

- Macro `PHASE_MON_ERRCNT_EN`.
- Defined: `err_count` is an 8-bit saturating counter.
  - Increments on each `err` and holds at 255.
  - Cleared by `reset` or `clr_err`.
- Undefined: the counter is not built and `err_count` is tied to 8'h00.
- All other behaviour is identical with or without the macro.

## Test plan

- Reset, then `v` = 0 for 9 cycles, then rotation starting 8'h01 → `phase_valid` rises one cycle after 8'h01. `phase` runs 0..7. First `cycle_done` appears with `phase` = 7, then `cycle_count` = 1.
- 20 full rotations (160 cycles) with CYC_W = 4 → `cycle_count` wraps: 15→0 on rotation 16, reads 4 at the end. No `err` pulses.
- LOCKED at `phase` = 3, inject 8'h20 instead of 8'h10 → `err` pulse, `err_sticky` = 1, `phase_valid` = 0, FAULT for 1 cycle, HUNT. Relock on the next 8'h01.
- LOCKED, inject multi-hot 8'h03, then `clr_err` asserted on the same edge as a second violation → `err_sticky` stays 1. Under the macro, `err_count` = 1.
- Under the macro, 300 violations (alternate 8'h00 bursts and relocks) → `err_count` saturates at 255. Without the macro → `err_count` = 0 throughout.
- Assert `reset` mid-rotation at `phase` = 5 with `cycle_count` = 7 → next cycle: HUNT, all outputs zero. The strobes still present are ignored until 8'h01.

Source files
------------

// File: rtl/cpu_phase_monitor.sv
// Decodes the eight one-hot CPU phase strobes into a binary phase index, counts completed
// instruction cycles and flags ring violations. Optional err_count built under PHASE_MON_ERRCNT_EN.
module cpu_phase_monitor #(
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clock_1,
    input  logic             clock_2,
    input  logic             clock_3,
    input  logic             clock_4,
    input  logic             clock_5,
    input  logic             clock_6,
    input  logic             clock_7,
    input  logic             clock_8,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             cycle_done,
    output logic [CYC_W-1:0] cycle_count,
    output logic             err,
    output logic             err_sticky,
    output logic [7:0]       err_count
);

    localparam int unsigned PH_W  = 3;
    localparam int unsigned VEC_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               phase_valid_q, phase_valid_d;
    logic               cycle_done_q, cycle_done_d;
    logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;
    logic               err_q, err_d;
    logic               err_sticky_q, err_sticky_d;

    logic [VEC_W-1:0]   vec;
    logic [PH_W-1:0]    phase_nxt;
    logic [VEC_W-1:0]   vec_exp;

    // State and output registers; reset dominates everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            cycle_done_q  <= 1'b0;
            cycle_count_q <= '0;
            err_q         <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            cycle_done_q  <= cycle_done_d;
            cycle_count_q <= cycle_count_d;
            err_q         <= err_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        vec           = {clock_8, clock_7, clock_6, clock_5, clock_4, clock_3, clock_2, clock_1};
        phase_nxt     = phase_q + PH_W'(1);
        vec_exp       = VEC_W'(1) << phase_nxt;
        state_d       = state_q;
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        cycle_done_d  = 1'b0;
        cycle_count_d = cycle_count_q;
        err_d         = 1'b0;

        case (state_q)
            HUNT: begin
                phase_valid_d = 1'b0;
                if (vec == VEC_W'(1)) begin
                    state_d       = LOCKED;
                    phase_d       = '0;
                    phase_valid_d = 1'b1;
                end
            end
            LOCKED: begin
                if (vec == vec_exp) begin
                    phase_d       = phase_nxt;
                    phase_valid_d = 1'b1;
                    if (phase_nxt == PH_W'(7)) begin
                        cycle_done_d  = 1'b1;
                        cycle_count_d = cycle_count_q + CYC_W'(1);
                    end
                end else begin
                    // phase keeps its last value so debug can see where the ring broke
                    state_d       = FAULT;
                    phase_valid_d = 1'b0;
                    err_d         = 1'b1;
                end
            end
            FAULT: begin
                state_d       = HUNT;
                phase_valid_d = 1'b0;
            end
            default: begin
                state_d       = HUNT;
                phase_valid_d = 1'b0;
            end
        endcase

        // A new violation beats a simultaneous clear
        err_sticky_d = err_d | (err_sticky_q & ~clr_err);
    end

`ifdef PHASE_MON_ERRCNT_EN
    localparam int unsigned ERRCNT_W = 8;

    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic [ERRCNT_W-1:0] err_count_base;

    // Saturating violation counter; clear applies before the increment
    always_comb begin
        err_count_base = clr_err ? '0 : err_count_q;
        err_count_d    = err_count_base;
        if (err_d && (err_count_base != {ERRCNT_W{1'b1}})) begin
            err_count_d = err_count_base + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign cycle_done  = cycle_done_q;
    assign cycle_count = cycle_count_q;
    assign err         = err_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_cpu_phase_monitor.sv
// Directed self-checking bench for cpu_phase_monitor (CYC_W = 4 so the cycle counter wraps).
module tb_cpu_phase_monitor;

    localparam int unsigned CYC_W = 4;

`ifdef PHASE_MON_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       v;
    logic             clr_err;
    logic [2:0]       phase;
    logic             phase_valid;
    logic             cycle_done;
    logic [CYC_W-1:0] cycle_count;
    logic             err;
    logic             err_sticky;
    logic [7:0]       err_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_phase_monitor #(.CYC_W(CYC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .clock_1     (v[0]),
        .clock_2     (v[1]),
        .clock_3     (v[2]),
        .clock_4     (v[3]),
        .clock_5     (v[4]),
        .clock_6     (v[5]),
        .clock_7     (v[6]),
        .clock_8     (v[7]),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count),
        .err         (err),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply a vector, clock once, then sample 1 time unit after the edge
    task automatic step(input logic [7:0] vec);
        v = vec;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_valid"}, 32'(phase_valid), 32'd0);
        chk({tag, "_done"}, 32'(cycle_done), 32'd0);
        chk({tag, "_count"}, 32'(cycle_count), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_sticky"}, 32'(err_sticky), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
    endtask

    int exp_cnt;
    int err_seen;

    initial begin
        reset   = 1'b1;
        clr_err = 1'b0;
        v       = 8'h00;
        step(8'h00);
        step(8'h00);
        chk_all_zero("reset");

        // Quiet ring after reset: no lock, no error
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(8'h00);
            chk("quiet_valid", 32'(phase_valid), 32'd0);
            chk("quiet_err", 32'(err), 32'd0);
        end

        // First rotation
        for (int i = 0; i < 8; i++) begin
            step(8'(1) << i);
            chk("rot1_phase", 32'(phase), 32'(i));
            chk("rot1_valid", 32'(phase_valid), 32'd1);
            chk("rot1_done", 32'(cycle_done), (i == 7) ? 32'd1 : 32'd0);
            chk("rot1_count", 32'(cycle_count), (i == 7) ? 32'd1 : 32'd0);
        end

        // Rotations 2..20: counter wraps at 16
        err_seen = 0;
        for (int r = 2; r <= 20; r++) begin
            for (int i = 0; i < 8; i++) begin
                step(8'(1) << i);
                if (err) err_seen++;
            end
            chk("rot_done", 32'(cycle_done), 32'd1);
            chk("rot_count", 32'(cycle_count), 32'(r % 16));
        end
        chk("rot_no_err", 32'(err_seen), 32'd0);
        chk("rot_sticky", 32'(err_sticky), 32'd0);

        // Wrong one-hot at phase 3
        for (int i = 0; i < 4; i++) step(8'(1) << i);
        chk("p3_phase", 32'(phase), 32'd3);
        step(8'h20);
        chk("wrong_err", 32'(err), 32'd1);
        chk("wrong_sticky", 32'(err_sticky), 32'd1);
        chk("wrong_valid", 32'(phase_valid), 32'd0);
        chk("wrong_phase_hold", 32'(phase), 32'd3);
        chk("wrong_errcnt", 32'(err_count), ERRCNT_ON ? 32'd1 : 32'd0);
        step(8'h01);
        chk("fault_ignores_01", 32'(phase_valid), 32'd0);
        chk("fault_err_pulse", 32'(err), 32'd0);
        step(8'h01);
        chk("relock_valid", 32'(phase_valid), 32'd1);
        chk("relock_phase", 32'(phase), 32'd0);
        chk("relock_count", 32'(cycle_count), 32'd4);

        // Multi-hot violation
        step(8'h03);
        chk("multi_err", 32'(err), 32'd1);
        chk("multi_errcnt", 32'(err_count), ERRCNT_ON ? 32'd2 : 32'd0);
        step(8'h00);
        step(8'h01);
        chk("multi_relock", 32'(phase_valid), 32'd1);

        // Clear coincident with a new violation: set wins
        clr_err = 1'b1;
        step(8'h00);
        clr_err = 1'b0;
        chk("clrset_err", 32'(err), 32'd1);
        chk("clrset_sticky", 32'(err_sticky), 32'd1);
        chk("clrset_errcnt", 32'(err_count), ERRCNT_ON ? 32'd1 : 32'd0);

        // Plain clear while in FAULT
        clr_err = 1'b1;
        step(8'h00);
        clr_err = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        chk("clr_errcnt", 32'(err_count), 32'd0);

        // 300 violations: lock, zero burst, fault cycle
        err_seen = 0;
        for (int k = 0; k < 300; k++) begin
            step(8'h01);
            step(8'h00);
            if (err) err_seen++;
            step(8'h00);
        end
        chk("sat_err_pulses", 32'(err_seen), 32'd300);
        chk("sat_errcnt", 32'(err_count), ERRCNT_ON ? 32'd255 : 32'd0);
        chk("sat_sticky", 32'(err_sticky), 32'd1);
        chk("sat_count_kept", 32'(cycle_count), 32'd4);

        // Bring cycle_count to 7, stop at phase 5
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) step(8'(1) << i);
        end
        for (int i = 0; i < 6; i++) step(8'(1) << i);
        exp_cnt = 7;
        chk("pre_rst_phase", 32'(phase), 32'd5);
        chk("pre_rst_count", 32'(cycle_count), 32'(exp_cnt));

        // Reset mid-rotation with strobe present
        reset = 1'b1;
        step(8'h40);
        chk_all_zero("midrst");
        reset = 1'b0;
        step(8'h80);
        chk("post_rst_stale_valid", 32'(phase_valid), 32'd0);
        chk("post_rst_stale_err", 32'(err), 32'd0);
        step(8'h02);
        chk("post_rst_stale2_valid", 32'(phase_valid), 32'd0);
        step(8'h01);
        chk("post_rst_lock_valid", 32'(phase_valid), 32'd1);
        chk("post_rst_lock_phase", 32'(phase), 32'd0);
        chk("post_rst_lock_count", 32'(cycle_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
